ahb_bram_ctrl: RTL and testbench
================================

# ahb_bram_ctrl

AHB-Lite slave that sits between the Cortex-M0 bus matrix and the dual-port block RAM (write port A, registered read port B). It converts AHB address/data phases into byte-lane write enables and read addresses, gives zero-wait-state reads and writes, and forwards in-flight write data to a back-to-back read of the same word. Misaligned or oversized transfers get a two-cycle ERROR response.

## Interface

Parameters:
- ADDR_WIDTH, 14, word-address width of the attached RAM (capacity 4·2^ADDR_WIDTH bytes)

Ports:
- HCLK  in  1  single clock; also clocks the RAM
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; bits above ADDR_WIDTH+1 ignored (aliasing)
- HTRANS  in  2  transfer type; only HTRANS[1]=1 (NONSEQ/SEQ) is a transfer
- HSIZE  in  3  0=byte, 1=halfword, 2=word, others illegal
- HWRITE  in  1  1=write
- HREADY  in  1  bus-wide ready
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- BRAM_WADDR  out  ADDR_WIDTH  RAM write word address (registered)
- BRAM_WDATA  out  32  RAM write data, = HWDATA
- BRAM_WE  out  4  RAM byte write enables
- BRAM_RADDR  out  ADDR_WIDTH  RAM read word address, = HADDR[ADDR_WIDTH+1:2] (combinational)
- BRAM_RDATA  in  32  RAM registered read data (old-data on same-address write)

## Operation

- Accept: HSEL & HTRANS[1] & HREADY at a rising edge. Non-accepted cycles change nothing.
- Lane mask from HSIZE/HADDR[1:0]: byte → 1<<HADDR[1:0]; halfword → 4'b0011 (HADDR[1]=0) or 4'b1100 (HADDR[1]=1); word → 4'b1111.
- Illegal: HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]≠0. Illegal transfers never touch the RAM.
- Write accept (legal): register wr_pend=1, wr_addr, wr_mask. Data phase: BRAM_WE = wr_mask, BRAM_WADDR = wr_addr, RAM samples HWDATA at the end of the data phase.
- Read accept (legal): BRAM_RADDR already carries the address; register rd_pend=1. Data phase: HRDATA = BRAM_RDATA merged with forward data; HRDATA=0 outside a read data phase.
- Forwarding: if a read is accepted while wr_pend=1 and read word address = wr_addr, capture fwd_mask=wr_mask and fwd_data=HWDATA at that edge; in the read data phase each byte lane with fwd_mask set takes fwd_data, others take BRAM_RDATA. Otherwise fwd_mask=0.
- FSM states: OKAY, ERR1, ERR2.
  - OKAY: HREADYOUT=1, HRESP=0. Illegal accept → ERR1.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 → OKAY; a transfer accepted in ERR2 is processed normally (legal → data phase next cycle, illegal → ERR1).
- A write data phase overlapping a new accept is normal pipelining; both proceed.

## Timing

- Reset values (registers, applied at edge with HRESET=1): state=OKAY, HREADYOUT=1, HRESP=0, wr_pend=0, rd_pend=0, fwd_mask=0, BRAM_WADDR=0, BRAM_WE=0, HRDATA=0.
- BRAM_WE is additionally gated by !HRESET: no RAM write occurs at an edge where HRESET=1; a write in its data phase when reset asserts is dropped.
- Reset mid-error: return to OKAY, HRESP=0 next cycle.
- Read latency: address phase cycle N, HRDATA valid in cycle N+1 with HREADYOUT=1 (zero wait).
- Write latency: address phase N, RAM updated at end of N+1; read of same word accepted in N+1 returns new data in N+2 via forwarding; read accepted in N+2 or later reads RAM directly.
- Error: illegal accept in N → N+1 HREADYOUT=0/HRESP=1, N+2 HREADYOUT=1/HRESP=1, N+3 OKAY.
- HRDATA never depends combinationally on HADDR.

## Test plan

- Reset then word write 0x1000_0000 ← 0xDEADBEEF, idle, word read same → BRAM_WE=4'b1111 one cycle, HRDATA=0xDEADBEEF one cycle after read address phase, HRESP=0 throughout.
- Byte writes 0x11,0x22,0x33,0x44 to offsets 0..3 of word 0x40 (HSIZE=0) → BRAM_WE 0001,0010,0100,1000; later word read = 0x44332211.
- Word 0x80 holds 0xAAAAAAAA; halfword write 0x5555 to 0x82, read 0x80 in the very next cycle → HRDATA=0x5555AAAA (forwarded), no wait states.
- Write to 0x100 immediately followed by read of 0x104 → no forwarding, HRDATA = prior contents of 0x104.
- Word write to 0x102 (misaligned) → HREADYOUT 0 then 1 with HRESP=1 both cycles, BRAM_WE stays 0, word 0x100 unchanged; HSIZE=3 read gives same response, HRDATA=0.
- Assert HRESET in a write data phase and during ERR1 → BRAM_WE=0 that cycle, RAM unchanged, next cycle HREADYOUT=1, HRESP=0, HRDATA=0.

Source files
------------

// File: rtl/ahb_bram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bram_ctrl_if
// Description : AHB-Lite slave port plus dual-port block RAM port bundle for
//               ahb_bram_ctrl. The slave modport is the controller's view;
//               the master modport is the bus matrix / RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_bram_ctrl_if #(
    parameter int ADDR_WIDTH = 14
);
    // AHB-Lite side
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic                  HREADY;
    logic [31:0]           HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    // Block RAM side (write port A, registered read port B)
    logic [ADDR_WIDTH-1:0] BRAM_WADDR;
    logic [31:0]           BRAM_WDATA;
    logic [3:0]            BRAM_WE;
    logic [ADDR_WIDTH-1:0] BRAM_RADDR;
    logic [31:0]           BRAM_RDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, BRAM_RDATA,
        output HREADYOUT, HRESP, HRDATA, BRAM_WADDR, BRAM_WDATA, BRAM_WE, BRAM_RADDR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, BRAM_RDATA,
        input  HREADYOUT, HRESP, HRDATA, BRAM_WADDR, BRAM_WDATA, BRAM_WE, BRAM_RADDR
    );
endinterface
`default_nettype wire

// File: rtl/ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bram_ctrl
// Description : Zero-wait-state AHB-Lite slave in front of a dual-port block
//               RAM. Converts address/data phases into byte-lane write
//               enables and read addresses, forwards in-flight write data to
//               a back-to-back read of the same word, and answers illegal
//               transfers with a two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  wire logic      HCLK,
    input  wire logic      HRESET,
    ahb_bram_ctrl_if.slave bus
);

    localparam logic [1:0] S_OKAY = 2'd0;
    localparam logic [1:0] S_ERR1 = 2'd1;
    localparam logic [1:0] S_ERR2 = 2'd2;

    logic [1:0]            r_state;
    logic                  r_wr_pend;
    logic                  r_rd_pend;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [3:0]            r_wr_mask;
    logic [3:0]            r_fwd_mask;
    logic [31:0]           r_fwd_data;

    logic                  w_accept;
    logic                  w_illegal;
    logic [3:0]            w_mask;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_fwd_hit;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
    assign w_unused    = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

    assign w_word_addr = bus.HADDR[ADDR_WIDTH+1:2];
    assign w_accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_wr_acc    = w_accept & ~w_illegal &  bus.HWRITE;
    assign w_rd_acc    = w_accept & ~w_illegal & ~bus.HWRITE;
    // A read of the word whose write is in its data phase right now would
    // see stale RAM contents, so the write lanes are captured for merging.
    assign w_fwd_hit   = r_wr_pend & (w_word_addr == r_wr_addr);

    // Decode the byte-lane mask and alignment legality of the address phase
    always_comb begin
        w_mask    = 4'b0000;
        w_illegal = 1'b0;
        case (bus.HSIZE)
            3'd0: w_mask = 4'b0001 << bus.HADDR[1:0];
            3'd1: begin
                w_mask    = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                w_illegal = bus.HADDR[0];
            end
            3'd2: begin
                w_mask    = 4'b1111;
                w_illegal = |bus.HADDR[1:0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Response FSM: illegal accept -> stall with ERROR -> ERROR with ready
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_OKAY;
        end else begin
            case (r_state)
                S_OKAY:  r_state <= (w_accept & w_illegal) ? S_ERR1 : S_OKAY;
                S_ERR1:  r_state <= S_ERR2;
                S_ERR2:  r_state <= (w_accept & w_illegal) ? S_ERR1 : S_OKAY;
                default: r_state <= S_OKAY;
            endcase
        end
    end

    // Data-phase bookkeeping for writes, reads and write-to-read forwarding
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr_pend  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_mask  <= 4'b0000;
            r_fwd_mask <= 4'b0000;
            r_fwd_data <= 32'h0;
        end else begin
            r_wr_pend <= w_wr_acc;
            r_rd_pend <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_addr <= w_word_addr;
                r_wr_mask <= w_mask;
            end
            if (w_rd_acc && w_fwd_hit) begin
                r_fwd_mask <= r_wr_mask;
                r_fwd_data <= bus.HWDATA;
            end else begin
                r_fwd_mask <= 4'b0000;
            end
        end
    end

    // Per-lane merge of forwarded write data over the RAM read data
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_rdata[8*gi +: 8] = r_fwd_mask[gi] ? r_fwd_data[8*gi +: 8]
                                                   : bus.BRAM_RDATA[8*gi +: 8];
    end

    assign bus.HRDATA     = r_rd_pend ? w_rdata : 32'h0;
    assign bus.HREADYOUT  = (r_state != S_ERR1);
    assign bus.HRESP      = (r_state != S_OKAY);
    // A reset edge must never commit a write that is mid data phase.
    assign bus.BRAM_WE    = (r_wr_pend & ~HRESET) ? r_wr_mask : 4'b0000;
    assign bus.BRAM_WADDR = r_wr_addr;
    assign bus.BRAM_WDATA = bus.HWDATA;
    assign bus.BRAM_RADDR = w_word_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bram_ctrl
// Description : Self-checking bench for ahb_bram_ctrl. A behavioural RAM
//               stands in for the block RAM; a transaction-level memory model
//               predicts every response, plus literal checks per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bram_ctrl;

    localparam int AW     = 8;
    localparam int DEPTH  = 1 << AW;
    localparam int NBYTES = 4 * DEPTH;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    // Single-slave bus matrix: HREADY is this slave's HREADYOUT
    assign bus.HREADY = bus.HREADYOUT;

    // Behavioural dual-port RAM: byte-write port A, registered read port B
    logic [31:0] ram [DEPTH];
    logic [31:0] r_ram_rdata;
    assign bus.BRAM_RDATA = r_ram_rdata;
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++)
            if (bus.BRAM_WE[b]) ram[bus.BRAM_WADDR][8*b +: 8] <= bus.BRAM_WDATA[8*b +: 8];
        r_ram_rdata <= ram[bus.BRAM_RADDR];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Memory in program order: a write lands when its data phase completes,
    // and any later read sees it. Errors occupy a stall then a ready cycle.
    logic [7:0]  exp_mem [NBYTES];
    bit          model_on = 0;
    bit          pw_valid = 0;
    int          pw_addr  = 0;
    logic [3:0]  pw_mask  = 4'h0;
    bit          pr_valid = 0;
    logic [31:0] pr_data  = 32'h0;
    int          err_ph   = 0;   // 0 none, 1 stall cycle, 2 final cycle
    bit          m_acc, m_legal;
    int          m_addr, m_base, m_len;
    logic [3:0]  m_mask;

    initial begin
        for (int i = 0; i < NBYTES; i++) exp_mem[i] = 8'h00;
        forever begin
            @(posedge HCLK);
            if (HRESET) begin
                pw_valid = 0;
                pr_valid = 0;
                err_ph   = 0;
                model_on = 1;
            end else if (model_on) begin
                if (pw_valid)
                    for (int b = 0; b < 4; b++)
                        if (pw_mask[b]) exp_mem[pw_addr + b] = bus.HWDATA[8*b +: 8];
                m_acc  = bus.HSEL && bus.HTRANS[1] && (err_ph != 1);
                m_addr = int'(bus.HADDR[AW+1:0]);
                m_base = m_addr - (m_addr % 4);
                m_len  = 1 << bus.HSIZE;
                m_legal = (bus.HSIZE <= 3'd2) && (m_addr % m_len == 0);
                m_mask = 4'h0;
                for (int b = 0; b < 4; b++)
                    if (m_legal && (m_base + b >= m_addr) && (m_base + b < m_addr + m_len))
                        m_mask[b] = 1'b1;
                if (err_ph == 1)            err_ph = 2;
                else if (m_acc && !m_legal) err_ph = 1;
                else                        err_ph = 0;
                pw_valid = m_acc && m_legal && bus.HWRITE;
                pw_addr  = m_base;
                pw_mask  = m_mask;
                pr_valid = m_acc && m_legal && !bus.HWRITE;
                if (pr_valid)
                    pr_data = {exp_mem[m_base+3], exp_mem[m_base+2],
                               exp_mem[m_base+1], exp_mem[m_base]};
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge HCLK);
            if (model_on) begin
                chk("hreadyout", 32'(bus.HREADYOUT), 32'(err_ph != 1));
                chk("hresp",     32'(bus.HRESP),     32'(err_ph != 0));
                chk("hrdata",    bus.HRDATA,         pr_valid ? pr_data : 32'h0);
                chk("bram_we",   32'(bus.BRAM_WE),   (pw_valid && !HRESET) ? 32'(pw_mask) : 32'h0);
                if (pw_valid && !HRESET)
                    chk("bram_waddr", 32'(bus.BRAM_WADDR), 32'(pw_addr / 4));
                chk("bram_raddr", 32'(bus.BRAM_RADDR), 32'(bus.HADDR[AW+1:2]));
                chk("bram_wdata", bus.BRAM_WDATA, bus.HWDATA);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit sel, input logic [1:0] tr, input bit wr,
                         input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        bus.HSEL   = sel;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HWDATA = wd;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        drive(1'b1, 2'b10, 1'b1, a, sz, wd);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        drive(1'b1, 2'b10, 1'b0, a, sz, wd);
    endtask

    // Selected but BUSY: must not be taken as a transfer
    task automatic idle(input logic [31:0] wd);
        drive(1'b1, 2'b01, 1'b1, 32'h40, 3'd2, wd);
    endtask

    task automatic step();
        @(posedge HCLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
        HRESET = 1'b1;
        step();
        step();
        #1;
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(bus.HRESP),     32'h0);
        chk("rst_hrdata",    bus.HRDATA,         32'h0);
        HRESET = 1'b0;
        step();

        // Word write then word read of the same (aliased) address
        wr(32'h1000_0000, 3'd2, 32'h0); step();
        drive(1'b0, 2'b10, 1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF); #1;
        chk("t1_we", 32'(bus.BRAM_WE), 32'hF); step();
        idle(32'h0); #1;
        chk("t1_we_off", 32'(bus.BRAM_WE), 32'h0); step();
        rd(32'h1000_0000, 3'd2, 32'h0); step();
        idle(32'h0); #1;
        chk("t1_rdata", bus.HRDATA, 32'hDEADBEEF);
        chk("t1_resp",  32'(bus.HRESP), 32'h0); step();
        idle(32'h0); #1;
        chk("t1_rdata_clr", bus.HRDATA, 32'h0); step();

        // Pipelined byte writes to word 0x40
        wr(32'h40, 3'd0, 32'h0); step();
        wr(32'h41, 3'd0, 32'h0000_0011); #1; chk("t2_we0", 32'(bus.BRAM_WE), 32'h1); step();
        drive(1'b1, 2'b11, 1'b1, 32'h42, 3'd0, 32'h0000_2200); #1; chk("t2_we1", 32'(bus.BRAM_WE), 32'h2); step();
        drive(1'b1, 2'b11, 1'b1, 32'h43, 3'd0, 32'h0033_0000); #1; chk("t2_we2", 32'(bus.BRAM_WE), 32'h4); step();
        idle(32'h4400_0000); #1; chk("t2_we3", 32'(bus.BRAM_WE), 32'h8); step();
        idle(32'h0); step();
        rd(32'h40, 3'd2, 32'h0); step();
        idle(32'h0); #1; chk("t2_rdata", bus.HRDATA, 32'h44332211); step();

        // Halfword write forwarded into an immediately following read
        wr(32'h80, 3'd2, 32'h0); step();
        idle(32'hAAAAAAAA); step();
        wr(32'h82, 3'd1, 32'h0); step();
        rd(32'h80, 3'd2, 32'h5555_0000); step();
        idle(32'h0); #1;
        chk("t3_fwd_rdata", bus.HRDATA, 32'h5555AAAA);
        chk("t3_fwd_ready", 32'(bus.HREADYOUT), 32'h1); step();
        rd(32'h80, 3'd2, 32'h0); step();
        idle(32'h0); #1; chk("t3_ram_rdata", bus.HRDATA, 32'h5555AAAA); step();

        // Write to 0x100 then read of 0x104: no forwarding
        wr(32'h104, 3'd2, 32'h0); step();
        idle(32'h12345678); step();
        wr(32'h100, 3'd2, 32'h0); step();
        rd(32'h104, 3'd2, 32'hCAFEF00D); step();
        idle(32'h0); #1; chk("t4_nofwd", bus.HRDATA, 32'h12345678); step();

        // Misaligned word write: two-cycle ERROR, RAM untouched
        wr(32'h102, 3'd2, 32'h0); step();
        idle(32'hFFFFFFFF); #1;
        chk("t5_err1_rdy",  32'(bus.HREADYOUT), 32'h0);
        chk("t5_err1_resp", 32'(bus.HRESP),     32'h1);
        chk("t5_err1_we",   32'(bus.BRAM_WE),   32'h0); step();
        idle(32'h0); #1;
        chk("t5_err2_rdy",  32'(bus.HREADYOUT), 32'h1);
        chk("t5_err2_resp", 32'(bus.HRESP),     32'h1); step();
        idle(32'h0); #1; chk("t5_okay_resp", 32'(bus.HRESP), 32'h0); step();
        // Oversized read
        rd(32'h100, 3'd3, 32'h0); step();
        idle(32'h0); #1;
        chk("t5_sz3_rdy",    32'(bus.HREADYOUT), 32'h0);
        chk("t5_sz3_hrdata", bus.HRDATA, 32'h0); step();
        idle(32'h0); #1;
        chk("t5_sz3_resp2",  32'(bus.HRESP), 32'h1); step();
        // Misaligned halfword, then a legal read issued in the second ERROR cycle
        rd(32'h101, 3'd1, 32'h0); step();
        idle(32'h0); step();
        rd(32'h100, 3'd2, 32'h0); #1; chk("t5_err2_acc_resp", 32'(bus.HRESP), 32'h1); step();
        idle(32'h0); #1;
        chk("t5_word100", bus.HRDATA, 32'hCAFEF00D);
        chk("t5_resp_ok", 32'(bus.HRESP), 32'h0); step();

        // Reset during a write data phase: write dropped
        wr(32'h40, 3'd2, 32'h0); step();
        HRESET = 1'b1; idle(32'h99999999); #1;
        chk("t6_rst_we", 32'(bus.BRAM_WE), 32'h0); step();
        HRESET = 1'b0; idle(32'h0); #1;
        chk("t6_rdy",    32'(bus.HREADYOUT), 32'h1);
        chk("t6_resp",   32'(bus.HRESP),     32'h0);
        chk("t6_hrdata", bus.HRDATA,         32'h0); step();
        rd(32'h40, 3'd2, 32'h0); step();
        idle(32'h0); #1; chk("t6_kept", bus.HRDATA, 32'h44332211); step();
        // Reset during the stall cycle of an ERROR
        rd(32'h43, 3'd2, 32'h0); step();
        HRESET = 1'b1; idle(32'h0); #1;
        chk("t6_err1_rdy", 32'(bus.HREADYOUT), 32'h0); step();
        HRESET = 1'b0; #1;
        chk("t6_err_rst_rdy",  32'(bus.HREADYOUT), 32'h1);
        chk("t6_err_rst_resp", 32'(bus.HRESP),     32'h0); step();
        idle(32'h0); step();

        // Final RAM image against the model memory
        begin
            int nbad;
            nbad = 0;
            for (int w = 0; w < DEPTH; w++)
                if (ram[w] !== {exp_mem[4*w+3], exp_mem[4*w+2], exp_mem[4*w+1], exp_mem[4*w]})
                    nbad++;
            chk("ram_image_bad_words", 32'(nbad), 32'h0);
        end
        chk("ram_word40", ram[32'h40 >> 2], 32'h44332211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
